// File: rtl/pwm_update_sequencer_pkg.sv
// PWM update sequencer: shared state encoding and pipeline constants.
// Optional build macro: PWM_UPDATE_SEQUENCER_CLAMP_EN (see pwm_edge_calc).
package pwm_update_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } seq_state_t;

  // Register stages inside the edge calculator
  localparam int unsigned CALC_LAT = 1;

endpackage

// File: rtl/pwm_update_sequencer_if.sv
// PWM update sequencer bus: control handshake, settings memory port, edge buffer write port.
interface pwm_update_sequencer_if #(
  parameter int unsigned WIDTH     = 13,
  parameter int unsigned TRANS_NUM = 249
);
  localparam int unsigned AW = $clog2(TRANS_NUM);

  logic             START;
  logic             BUSY;
  logic             DONE;
  logic [AW-1:0]    MEM_ADDR;
  logic [WIDTH-1:0] MEM_CYCLE;
  logic [WIDTH-1:0] MEM_DUTY;
  logic [WIDTH-1:0] MEM_PHASE;
  logic             OUT_WE;
  logic [AW-1:0]    OUT_IDX;
  logic [WIDTH-1:0] OUT_RISE;
  logic [WIDTH-1:0] OUT_FALL;

  // Host / memory / edge buffer side
  modport master (
    output START, MEM_CYCLE, MEM_DUTY, MEM_PHASE,
    input  BUSY, DONE, MEM_ADDR, OUT_WE, OUT_IDX, OUT_RISE, OUT_FALL
  );

  // Sequencer side
  modport slave (
    input  START, MEM_CYCLE, MEM_DUTY, MEM_PHASE,
    output BUSY, DONE, MEM_ADDR, OUT_WE, OUT_IDX, OUT_RISE, OUT_FALL
  );

endinterface

// File: rtl/pwm_edge_calc.sv
// Rise/fall time-counter calculation with one output register stage.
// Optional build macro: PWM_UPDATE_SEQUENCER_CLAMP_EN clamps duty and phase to the cycle.
module pwm_edge_calc
  import pwm_update_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] cycle,
  input  logic [WIDTH-1:0] duty,
  input  logic [WIDTH-1:0] phase,
  output logic             out_valid,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int unsigned IW = WIDTH + 2;

  logic [IW-1:0] c_w;
  logic [IW-1:0] d_w;
  logic [IW-1:0] p_w;
  logic [IW-1:0] r_raw;
  logic [IW-1:0] f_raw;
  logic [IW-1:0] r_mod;
  logic [IW-1:0] f_mod;

  // Raw values lie in [0, 2C], so two conditional subtractions complete the modulo
  function automatic logic [IW-1:0] mod_c(input logic [IW-1:0] x, input logic [IW-1:0] c);
    logic [IW-1:0] y;
    y = x;
    if (y >= c) y = y - c;
    if (y >= c) y = y - c;
    return y;
  endfunction

  // Operand conditioning and edge arithmetic
  always_comb begin
    c_w = IW'(cycle);
`ifdef PWM_UPDATE_SEQUENCER_CLAMP_EN
    d_w = (duty  > cycle) ? IW'(cycle) : IW'(duty);
    p_w = (phase > cycle) ? IW'(cycle) : IW'(phase);
`else
    d_w = IW'(duty);
    p_w = IW'(phase);
`endif
    r_raw = (c_w << 1) - p_w - (d_w >> 1);
    f_raw = c_w - p_w + ((d_w + IW'(1)) >> 1);
    r_mod = mod_c(r_raw, c_w);
    f_mod = mod_c(f_raw, c_w);
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      rise      <= '0;
      fall      <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        rise <= WIDTH'(r_mod);
        fall <= WIDTH'(f_mod);
      end
    end
  end

endmodule

// File: rtl/pwm_update_sequencer.sv
// Sweeps the settings memory once per START and writes computed rise/fall edges per transducer.
// Optional build macro: PWM_UPDATE_SEQUENCER_CLAMP_EN (duty/phase clamp in pwm_edge_calc).
module pwm_update_sequencer
  import pwm_update_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH     = 13,
  parameter int unsigned TRANS_NUM = 249,
  parameter int unsigned MEM_LAT   = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  pwm_update_sequencer_if.slave bus
);

  localparam int unsigned AW       = $clog2(TRANS_NUM);
  localparam int unsigned IDX_LAT  = MEM_LAT + CALC_LAT;
  localparam logic [AW-1:0] LAST_IDX = AW'(TRANS_NUM - 1);

  seq_state_t    state;
  seq_state_t    state_nxt;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr_nxt;
  logic          busy;
  logic          busy_nxt;
  logic          done;
  logic          done_nxt;

  logic [MEM_LAT-1:0] rd_vld;
  logic [AW-1:0]      idx_dly [IDX_LAT];

  // State and registered control outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      addr  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state, address counter and control output decode
  always_comb begin
    state_nxt = state;
    addr_nxt  = '0;
    case (state)
      IDLE: begin
        if (bus.START) state_nxt = SWEEP;
      end
      SWEEP: begin
        if (addr == LAST_IDX) state_nxt = DRAIN;
        else                  addr_nxt  = addr + AW'(1);
      end
      DRAIN: begin
        if (bus.OUT_WE && (bus.OUT_IDX == LAST_IDX)) state_nxt = FINISH;
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == FINISH);
  end

  // Read-valid and index delay lines aligned to memory latency plus calc stage
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_vld <= '0;
      for (int i = 0; i < int'(IDX_LAT); i++) idx_dly[i] <= '0;
    end else begin
      rd_vld[0]  <= (state == SWEEP);
      idx_dly[0] <= addr;
      for (int i = 1; i < int'(MEM_LAT); i++) rd_vld[i]  <= rd_vld[i-1];
      for (int i = 1; i < int'(IDX_LAT); i++) idx_dly[i] <= idx_dly[i-1];
    end
  end

  pwm_edge_calc #(
    .WIDTH (WIDTH)
  ) u_edge_calc (
    .clk       (CLK),
    .rst       (RST),
    .in_valid  (rd_vld[MEM_LAT-1]),
    .cycle     (bus.MEM_CYCLE),
    .duty      (bus.MEM_DUTY),
    .phase     (bus.MEM_PHASE),
    .out_valid (bus.OUT_WE),
    .rise      (bus.OUT_RISE),
    .fall      (bus.OUT_FALL)
  );

  assign bus.BUSY     = busy;
  assign bus.DONE     = done;
  assign bus.MEM_ADDR = addr;
  assign bus.OUT_IDX  = idx_dly[IDX_LAT-1];

endmodule

// File: tb/tb_pwm_update_sequencer.sv
// Scoreboard bench for pwm_update_sequencer: directed and random sweeps against an arithmetic model.
module tb_pwm_update_sequencer;

  localparam int WIDTH       = 13;
  localparam int TRANS_NUM   = 249;
  localparam int MEM_LAT     = 2;
  localparam int SWEEP_LIMIT = 400;

  typedef struct {
    int idx;
    int rise;
    int fall;
    int cyc;
  } wr_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  wr_t exp_wr[$];
  wr_t exp_addr[$];
  int  exp_done[$];

  logic [WIDTH-1:0] mem_c [TRANS_NUM];
  logic [WIDTH-1:0] mem_d [TRANS_NUM];
  logic [WIDTH-1:0] mem_p [TRANS_NUM];
  logic [WIDTH-1:0] pc [MEM_LAT];
  logic [WIDTH-1:0] pd [MEM_LAT];
  logic [WIDTH-1:0] pp [MEM_LAT];

  pwm_update_sequencer_if #(.WIDTH(WIDTH), .TRANS_NUM(TRANS_NUM)) bus ();

  pwm_update_sequencer #(
    .WIDTH     (WIDTH),
    .TRANS_NUM (TRANS_NUM),
    .MEM_LAT   (MEM_LAT)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Settings memory with fixed read latency
  always @(posedge CLK) begin
    if (int'(bus.MEM_ADDR) < TRANS_NUM) begin
      pc[0] <= mem_c[bus.MEM_ADDR];
      pd[0] <= mem_d[bus.MEM_ADDR];
      pp[0] <= mem_p[bus.MEM_ADDR];
    end else begin
      pc[0] <= '0;
      pd[0] <= '0;
      pp[0] <= '0;
    end
    for (int j = 1; j < MEM_LAT; j++) begin
      pc[j] <= pc[j-1];
      pd[j] <= pd[j-1];
      pp[j] <= pp[j-1];
    end
  end
  assign bus.MEM_CYCLE = pc[MEM_LAT-1];
  assign bus.MEM_DUTY  = pd[MEM_LAT-1];
  assign bus.MEM_PHASE = pp[MEM_LAT-1];

  task automatic chk(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Reference: edge times straight from the modular formulas
  function automatic void model(input int c, input int d, input int p, output int r, output int f);
`ifdef PWM_UPDATE_SEQUENCER_CLAMP_EN
    if (d > c) d = c;
    if (p > c) p = c;
`endif
    r = (2 * c - p - d / 2) % c;
    f = (c - p + (d + 1) / 2) % c;
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < TRANS_NUM; i++) begin
      int c, d, p;
      case (mode)
        0: begin c = 4096; d = 0;    p = 0;    end
        1: begin c = 4096; d = 1000; p = 2048; end
        2: if (i % 2 == 0) begin c = 4096; d = 1; p = 0; end
           else begin c = 4096; d = 4096; p = 2048; end
        3: begin
          c = int'($urandom_range(8000, 2000));
          d = int'($urandom_range(c, 0));
          p = int'($urandom_range(c, 0));
        end
        default: begin c = 2000; d = 2001; p = 0; end
      endcase
      mem_c[i] = WIDTH'(c);
      mem_d[i] = WIDTH'(d);
      mem_p[i] = WIDTH'(p);
    end
  endtask

  task automatic check_idle(input string name);
    chk(bus.BUSY == 1'b0 && bus.DONE == 1'b0 && bus.OUT_WE == 1'b0 && bus.MEM_ADDR == '0,
        name, $sformatf("busy=%0b done=%0b we=%0b addr=%0d, required all 0",
                        bus.BUSY, bus.DONE, bus.OUT_WE, bus.MEM_ADDR));
  endtask

  // One sweep; rst_at / restart_at are cycles after START (-1 = unused)
  task automatic sweep(input int rst_at, input int restart_at);
    int  s;
    bit  finished;
    wr_t e;
    @(posedge CLK); #1;
    s = cyc;
    for (int i = 0; i < TRANS_NUM; i++) begin
      int r, f;
      model(int'(mem_c[i]), int'(mem_d[i]), int'(mem_p[i]), r, f);
      e.idx = i; e.rise = r; e.fall = f;
      e.cyc = s + i + MEM_LAT + 2;
      if (rst_at < 0 || e.cyc <= s + rst_at) exp_wr.push_back(e);
      e.cyc = s + 1 + i;
      if (rst_at < 0 || e.cyc <= s + rst_at) exp_addr.push_back(e);
    end
    if (rst_at < 0) exp_done.push_back(s + TRANS_NUM + MEM_LAT + 2);
    bus.START = 1'b1;
    @(posedge CLK); #1;
    finished = 1'b0;
    for (int k = 1; k <= SWEEP_LIMIT; k++) begin
      bus.START = (k == restart_at) || (k == rst_at);
      RST       = (k == rst_at);
      if (rst_at >= 0 && k == rst_at + 1) begin
        chk(bus.OUT_IDX == '0 && bus.OUT_RISE == '0 && bus.OUT_FALL == '0,
            "abort_outputs", $sformatf("idx=%0d rise=%0d fall=%0d, required 0 0 0",
                                       bus.OUT_IDX, bus.OUT_RISE, bus.OUT_FALL));
        check_idle("abort_state");
      end
      if (rst_at >= 0 ? (k > rst_at + 1) : (exp_done.size() == 0)) begin
        finished = 1'b1;
        break;
      end
      @(posedge CLK); #1;
    end
    bus.START = 1'b0;
    RST       = 1'b0;
    if (!finished) begin
      chk(1'b0, "done_timeout", $sformatf("no DONE within %0d cycles, required DONE at cycle %0d",
                                           SWEEP_LIMIT, TRANS_NUM + MEM_LAT + 2));
      exp_done.delete();
    end
    repeat (6) @(posedge CLK);
    #1;
    chk(exp_wr.size() == 0 && exp_addr.size() == 0, "scoreboard_drain",
        $sformatf("pending writes=%0d addrs=%0d, required 0 0", exp_wr.size(), exp_addr.size()));
    check_idle("idle_after_sweep");
    exp_wr.delete();
    exp_addr.delete();
  endtask

  // Monitor: pops scoreboard entries whenever the DUT presents an output
  wr_t m_e;
  int  m_d;
  always @(negedge CLK) begin
    if (bus.OUT_WE) begin
      if (exp_wr.size() == 0) begin
        chk(1'b0, "unexpected_write", $sformatf("idx=%0d at cycle %0d, required no write",
                                                bus.OUT_IDX, cyc));
      end else begin
        m_e = exp_wr.pop_front();
        chk(int'(bus.OUT_IDX) == m_e.idx && int'(bus.OUT_RISE) == m_e.rise &&
            int'(bus.OUT_FALL) == m_e.fall && cyc == m_e.cyc && bus.BUSY == 1'b1, "write",
            $sformatf("idx=%0d rise=%0d fall=%0d cyc=%0d busy=%0b, required idx=%0d rise=%0d fall=%0d cyc=%0d busy=1",
                      bus.OUT_IDX, bus.OUT_RISE, bus.OUT_FALL, cyc, bus.BUSY,
                      m_e.idx, m_e.rise, m_e.fall, m_e.cyc));
      end
    end
    if (exp_addr.size() != 0 && exp_addr[0].cyc == cyc) begin
      m_e = exp_addr.pop_front();
      chk(int'(bus.MEM_ADDR) == m_e.idx, "mem_addr",
          $sformatf("addr=%0d at cycle %0d, required %0d", bus.MEM_ADDR, cyc, m_e.idx));
    end
    if (bus.DONE) begin
      if (exp_done.size() == 0) begin
        chk(1'b0, "unexpected_done", $sformatf("DONE at cycle %0d, required none", cyc));
      end else begin
        m_d = exp_done.pop_front();
        chk(cyc == m_d && bus.BUSY == 1'b1 && bus.MEM_ADDR == '0 && exp_wr.size() == 0, "done",
            $sformatf("cycle=%0d busy=%0b addr=%0d pending=%0d, required cycle=%0d busy=1 addr=0 pending=0",
                      cyc, bus.BUSY, bus.MEM_ADDR, exp_wr.size(), m_d));
      end
    end
  end

  initial begin
    bus.START = 1'b0;
    RST = 1'b1;
    fill(0);
    repeat (3) @(posedge CLK);
    #1;
    check_idle("reset_state");
    chk(bus.OUT_IDX == '0 && bus.OUT_RISE == '0 && bus.OUT_FALL == '0, "reset_outputs",
        $sformatf("idx=%0d rise=%0d fall=%0d, required 0 0 0",
                  bus.OUT_IDX, bus.OUT_RISE, bus.OUT_FALL));
    RST = 1'b0;

    fill(0); sweep(-1, -1);
    fill(1); sweep(-1, -1);
    fill(2); sweep(-1, -1);
    fill(1); sweep(-1, 100);
    fill(1); sweep(50, -1);
    fill(2); sweep(-1, -1);
`ifdef PWM_UPDATE_SEQUENCER_CLAMP_EN
    fill(4); sweep(-1, -1);
`endif
    for (int n = 0; n < 100; n++) begin
      fill(3);
      sweep(-1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
